// File: rtl/seg7_count_checker.sv
// seg7_count_checker
//   Receive-side monitor for a decimal counter driving a 7-segment bus. The bus is
//   resynchronised, deglitched by requiring a pattern to hold for STABLE_CYCLES
//   synchronised cycles, decoded back to BCD, and each newly accepted digit is
//   checked against the expected successor of the previous one. Illegal patterns,
//   sequence breaks and stalls raise sticky error flags.
//
// Ports
//   clk           clock
//   rst           asynchronous reset, active-high
//   clr           synchronous clear with the same effect as rst (wins over any same-cycle event)
//   dir           expected count direction: 0 = up (9->0 wrap), 1 = down (0->9 wrap)
//   seg_in[6:0]   segments a..g on bits 0..6, active-high, asynchronous to clk
//   digit[3:0]    last accepted BCD digit
//   digit_valid   digit holds a decoded value
//   accept_pulse  one-cycle strobe when digit updates
//   err_seq       sticky: accepted digit was not the expected successor
//   err_invalid   sticky: a stable, undecodable pattern was seen
//   err_timeout   sticky: no accepted digit for TIMEOUT_CYCLES while tracking
//   n_changes     number of accepted digits, saturating at all-ones
module seg7_count_checker #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             dir,
    input  logic [6:0]       seg_in,
    output logic [3:0]       digit,
    output logic             digit_valid,
    output logic             accept_pulse,
    output logic             err_seq,
    output logic             err_invalid,
    output logic             err_timeout,
    output logic [CNT_W-1:0] n_changes
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT_CYCLES);

    typedef enum logic {S_SYNC, S_TRACK} state_t;

    // Returns {legal, bcd}; anything outside the ten digit codes is illegal.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h3F:   decode = {1'b1, 4'd0};
            7'h06:   decode = {1'b1, 4'd1};
            7'h5B:   decode = {1'b1, 4'd2};
            7'h4F:   decode = {1'b1, 4'd3};
            7'h66:   decode = {1'b1, 4'd4};
            7'h6D:   decode = {1'b1, 4'd5};
            7'h7D:   decode = {1'b1, 4'd6};
            7'h07:   decode = {1'b1, 4'd7};
            7'h7F:   decode = {1'b1, 4'd8};
            7'h6F:   decode = {1'b1, 4'd9};
            default: decode = 5'b0_0000;
        endcase
    endfunction

    function automatic logic [3:0] successor(input logic [3:0] d, input logic down);
        if (down) successor = (d == 4'd0) ? 4'd9 : d - 4'd1;
        else      successor = (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    logic [6:0]       sync1_q, sync2_q, prev_q, last_q;
    logic [SW-1:0]    stab_q, stab_d;
    logic [TW-1:0]    tmo_q;
    state_t           state_q;
    logic [3:0]       digit_q;
    logic             valid_q, pulse_q, err_seq_q, err_inv_q, err_to_q;
    logic [CNT_W-1:0] n_q;

    logic       changed, reach, accept, legal;
    logic [3:0] bcd;

    always_comb begin
        changed = (sync2_q != prev_q);
        if (changed)                  stab_d = SW'(1);
        else if (stab_q == STABLE_MAX) stab_d = stab_q;
        else                          stab_d = stab_q + 1'b1;
        // Only the edge that first reaches the threshold counts, so a held
        // pattern is considered exactly once per appearance.
        reach  = (stab_d == STABLE_MAX) && (changed || (stab_q != STABLE_MAX));
        accept = reach && (sync2_q != last_q);
        {legal, bcd} = decode(sync2_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            last_q    <= '0;
            stab_q    <= '0;
            tmo_q     <= '0;
            state_q   <= S_SYNC;
            digit_q   <= '0;
            valid_q   <= 1'b0;
            pulse_q   <= 1'b0;
            err_seq_q <= 1'b0;
            err_inv_q <= 1'b0;
            err_to_q  <= 1'b0;
            n_q       <= '0;
        end else if (clr) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            last_q    <= '0;
            stab_q    <= '0;
            tmo_q     <= '0;
            state_q   <= S_SYNC;
            digit_q   <= '0;
            valid_q   <= 1'b0;
            pulse_q   <= 1'b0;
            err_seq_q <= 1'b0;
            err_inv_q <= 1'b0;
            err_to_q  <= 1'b0;
            n_q       <= '0;
        end else begin
            sync1_q <= seg_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            stab_q  <= stab_d;
            pulse_q <= 1'b0;
            if (accept) last_q <= sync2_q;

            case (state_q)
                S_SYNC: begin
                    if (accept) begin
                        if (legal) begin
                            // First digit after (re)sync seeds the reference unchecked.
                            digit_q <= bcd;
                            valid_q <= 1'b1;
                            pulse_q <= 1'b1;
                            tmo_q   <= '0;
                            state_q <= S_TRACK;
                            if (n_q != '1) n_q <= n_q + 1'b1;
                        end else begin
                            err_inv_q <= 1'b1;
                        end
                    end
                end
                S_TRACK: begin
                    if (accept) begin
                        if (legal) begin
                            if (bcd != successor(digit_q, dir)) err_seq_q <= 1'b1;
                            digit_q <= bcd;
                            pulse_q <= 1'b1;
                            tmo_q   <= '0;
                            if (n_q != '1) n_q <= n_q + 1'b1;
                        end else begin
                            err_inv_q <= 1'b1;
                            valid_q   <= 1'b0;
                            state_q   <= S_SYNC;
                        end
                    end else if ((TIMEOUT_CYCLES > 0) && (tmo_q != TMO_MAX)) begin
                        // Counter stops at the limit so the flag fires once.
                        tmo_q <= tmo_q + 1'b1;
                        if (tmo_q + 1'b1 == TMO_MAX) err_to_q <= 1'b1;
                    end
                end
                default: state_q <= S_SYNC;
            endcase
        end
    end

    assign digit        = digit_q;
    assign digit_valid  = valid_q;
    assign accept_pulse = pulse_q;
    assign err_seq      = err_seq_q;
    assign err_invalid  = err_inv_q;
    assign err_timeout  = err_to_q;
    assign n_changes    = n_q;

endmodule

// File: tb/tb_seg7_count_checker.sv
module tb_seg7_count_checker;
    localparam int S = 4;
    localparam int T = 64;
    localparam logic [6:0] CODES [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    localparam logic [6:0] T1 [11] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                       7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h3F};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        dir = 1'b0;
    logic [6:0]  seg_in = 7'h00;
    logic [3:0]  digit;
    logic        digit_valid, accept_pulse, err_seq, err_invalid, err_timeout;
    logic [15:0] n_changes;

    int n_cmp = 0;
    int n_bad = 0;

    seg7_count_checker #(
        .STABLE_CYCLES(S), .TIMEOUT_CYCLES(T), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr), .dir(dir), .seg_in(seg_in),
        .digit(digit), .digit_valid(digit_valid), .accept_pulse(accept_pulse),
        .err_seq(err_seq), .err_invalid(err_invalid), .err_timeout(err_timeout),
        .n_changes(n_changes)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: bus samples are taken at each edge; a pattern is seen
    // two edges later and is accepted when it has been seen for exactly S
    // consecutive edges and differs from the previously accepted pattern.
    logic [6:0] h0, h1, last_cand, last_acc;
    int  run, since, m_digit, m_n;
    bit  m_track, m_valid, m_pulse, m_eseq, m_einv, m_eto;

    function automatic int code_to_digit(input logic [6:0] p);
        for (int i = 0; i < 10; i++) if (CODES[i] == p) return i;
        return -1;
    endfunction

    task automatic model_reset();
        h0 = 7'h00; h1 = 7'h00; last_cand = 7'h00; last_acc = 7'h00;
        run = 0; since = 0; m_digit = 0; m_n = 0;
        m_track = 0; m_valid = 0; m_pulse = 0; m_eseq = 0; m_einv = 0; m_eto = 0;
    endtask

    task automatic model_step();
        logic [6:0] cand;
        int d;
        cand = h1;
        m_pulse = 0;
        if (cand == last_cand) run++; else run = 1;
        last_cand = cand;
        h1 = h0;
        h0 = seg_in;
        if (run == S && cand != last_acc) begin
            last_acc = cand;
            d = code_to_digit(cand);
            if (d < 0) begin
                m_einv = 1;
                if (m_track) begin m_track = 0; m_valid = 0; end
            end else begin
                if (m_track && d != (dir ? (m_digit + 9) % 10 : (m_digit + 1) % 10)) m_eseq = 1;
                m_digit = d; m_valid = 1; m_pulse = 1; m_track = 1; since = 0;
                if (m_n < 65535) m_n++;
            end
        end else if (m_track && T > 0 && since < T) begin
            since++;
            if (since == T) m_eto = 1;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst || clr) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("digit",        32'(digit),        32'(m_digit));
            check("digit_valid",  32'(digit_valid),  32'(m_valid));
            check("accept_pulse", 32'(accept_pulse), 32'(m_pulse));
            check("err_seq",      32'(err_seq),      32'(m_eseq));
            check("err_invalid",  32'(err_invalid),  32'(m_einv));
            check("err_timeout",  32'(err_timeout),  32'(m_eto));
            check("n_changes",    32'(n_changes),    32'(m_n));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic set_seg(input logic [6:0] p);
        @(posedge clk); #2;
        seg_in = p;
    endtask

    // Counts edges until accept_pulse; 0 means none within the window.
    task automatic wait_accept(input string name, input int exp_lat);
        int lat;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (accept_pulse) begin lat = i; break; end
        end
        check(name, 32'(lat), 32'(exp_lat));
    endtask

    task automatic apply(input string name, input logic [6:0] p);
        set_seg(p);
        wait_accept(name, S + 2);
        repeat (4) @(posedge clk);
    endtask

    task automatic pulse_clr();
        @(posedge clk); #2 clr = 1'b1;
        @(posedge clk); #2 clr = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_digit"}, 32'(digit),        32'd0);
        check({tag, "_valid"}, 32'(digit_valid),  32'd0);
        check({tag, "_pulse"}, 32'(accept_pulse), 32'd0);
        check({tag, "_eseq"},  32'(err_seq),      32'd0);
        check({tag, "_einv"},  32'(err_invalid),  32'd0);
        check({tag, "_eto"},   32'(err_timeout),  32'd0);
        check({tag, "_n"},     32'(n_changes),    32'd0);
    endtask

    initial begin
        int tlat;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        check_reset_vals("rst");

        // Full up-count 0..9,0
        for (int i = 0; i < 11; i++) apply($sformatf("t1_lat%0d", i), T1[i]);
        check("t1_n",    32'(n_changes),   32'd11);
        check("t1_dig",  32'(digit),       32'd0);
        check("t1_vld",  32'(digit_valid), 32'd1);
        check("t1_eseq", 32'(err_seq),     32'd0);
        check("t1_einv", 32'(err_invalid), 32'd0);
        check("t1_eto",  32'(err_timeout), 32'd0);

        // Skip from 2 to 4
        apply("t2_lat1", 7'h06);
        apply("t2_lat2", 7'h5B);
        set_seg(7'h66);
        wait_accept("t2_lat4", S + 2);
        check("t2_dig4", 32'(digit),   32'd4);
        check("t2_eseq", 32'(err_seq), 32'd1);
        apply("t2_lat5", 7'h6D);
        check("t2_dig5",    32'(digit),   32'd5);
        check("t2_sticky",  32'(err_seq), 32'd1);

        // Short glitch at 7
        pulse_clr();
        wait_accept("t3_reseed", S + 2);
        check("t3_dig5", 32'(digit),   32'd5);
        check("t3_eseq", 32'(err_seq), 32'd0);
        apply("t3_lat6", 7'h7D);
        apply("t3_lat7", 7'h07);
        set_seg(7'h7F);
        @(posedge clk);
        set_seg(7'h07);
        wait_accept("t3_noacc", 0);
        check("t3_dig7", 32'(digit),       32'd7);
        check("t3_vld",  32'(digit_valid), 32'd1);
        check("t3_eseq", 32'(err_seq),     32'd0);
        check("t3_einv", 32'(err_invalid), 32'd0);

        // Illegal pattern then re-seed
        pulse_clr();
        wait_accept("t4_reseed", S + 2);
        set_seg(7'h49);
        wait_accept("t4_noacc", 0);
        check("t4_einv", 32'(err_invalid), 32'd1);
        check("t4_vld0", 32'(digit_valid), 32'd0);
        set_seg(7'h5B);
        wait_accept("t4_lat2", S + 2);
        check("t4_dig2", 32'(digit),       32'd2);
        check("t4_vld1", 32'(digit_valid), 32'd1);
        check("t4_eseq", 32'(err_seq),     32'd0);

        // Down count and timeout
        @(posedge clk); #2;
        seg_in = 7'h3F; dir = 1'b1; clr = 1'b1;
        @(posedge clk); #2 clr = 1'b0;
        wait_accept("t5_seed", S + 2);
        check("t5_dig0", 32'(digit), 32'd0);
        apply("t5_lat9", 7'h6F);
        check("t5_dig9", 32'(digit), 32'd9);
        set_seg(7'h7F);
        wait_accept("t5_lat8", S + 2);
        check("t5_dig8", 32'(digit),       32'd8);
        check("t5_eseq", 32'(err_seq),     32'd0);
        check("t5_einv", 32'(err_invalid), 32'd0);
        tlat = 0;
        for (int i = 1; i <= 70; i++) begin
            @(posedge clk); #1;
            if (err_timeout) begin tlat = i; break; end
        end
        check("t5_tmo_at", 32'(tlat), 32'd64);

        // clr on the accepting edge, then asynchronous rst mid-window
        set_seg(7'h6F);
        dir = 1'b0;
        repeat (5) @(posedge clk);
        #2 clr = 1'b1;
        @(posedge clk); #1;
        check_reset_vals("t6_clr");
        clr = 1'b0;
        wait_accept("t6_reseed", S + 2);
        check("t6_dig9", 32'(digit),     32'd9);
        check("t6_eseq", 32'(err_seq),   32'd0);
        check("t6_n1",   32'(n_changes), 32'd1);
        set_seg(7'h3F);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_reset_vals("t6_rst");
        @(posedge clk); #2 rst = 1'b0;
        wait_accept("t6_rst_reseed", S + 2);
        check("t6_dig0",  32'(digit),     32'd0);
        check("t6_eseq2", 32'(err_seq),   32'd0);
        check("t6_n1b",   32'(n_changes), 32'd1);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
